ntt_lane_gather: RTL

Stride-gather buffer that feeds the radix-8 butterfly of the NTT datapath. It accepts a serial stream of polynomial coefficients, one per cycle, and reduces each into [0, M). It buffers 64-coefficient blocks (R×R) in a ping-pong pair of banks. Each block leaves as 8 stride-8 lanes of R coefficients, in exactly the lane_t order the butterfly consumes. Each block's NTT-direction flag travels with its lanes.

---
 rtl/ntt_lane_gather.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ntt_lane_gather.sv
// Stride-gather ping-pong buffer: reduces a serial coefficient stream mod M, collects R*R blocks
// and emits each block as R stride-R lanes for the radix-R butterfly.
module ntt_lane_gather #(
    parameter int unsigned R  = 8,
    parameter int unsigned DW = 14,
    parameter int unsigned M  = 12289
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_inv,
    output logic [R*DW-1:0] lane_out,
    output logic            valid_out,
    input  logic            out_ready,
    output logic            inv_out,
    output logic            lane_last
);

    localparam int unsigned N  = R * R;
    localparam int unsigned WW = $clog2(N);
    localparam int unsigned RW = $clog2(R);

    localparam logic [DW-1:0] MOD   = DW'(M);
    localparam logic [WW-1:0] WLAST = WW'(N - 1);
    localparam logic [RW-1:0] RLAST = RW'(R - 1);

    // Bank storage, not reset.
    logic [DW-1:0] mem_q [2][N];

    // Write side
    logic          wbank_q, wbank_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    inv_q, inv_d;

    // Read side
    logic          rbank_q, rbank_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Output register
    logic [R*DW-1:0] lane_q, lane_d;
    logic            valid_q, valid_d;
    logic            inv_out_q, inv_out_d;
    logic            last_q, last_d;
    logic            obank_q, obank_d;

    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          advance;
    logic          free_en;

    // 2*M > 2^DW - 1, so one conditional subtract fully reduces any input.
    assign wr_data  = (in_data >= MOD) ? (in_data - MOD) : in_data;

    assign in_ready = !full_q[wbank_q];
    assign wr_en    = in_valid && in_ready;
    assign advance  = !valid_q || out_ready;
    // A bank stays full until its last lane has been accepted downstream.
    assign free_en  = valid_q && out_ready && last_q;

    assign lane_out  = lane_q;
    assign valid_out = valid_q;
    assign inv_out   = inv_out_q;
    assign lane_last = last_q;

    always_comb begin
        wbank_d   = wbank_q;
        wcnt_d    = wcnt_q;
        full_d    = full_q;
        inv_d     = inv_q;
        rbank_d   = rbank_q;
        rcnt_d    = rcnt_q;
        lane_d    = lane_q;
        valid_d   = valid_q;
        inv_out_d = inv_out_q;
        last_d    = last_q;
        obank_d   = obank_q;

        if (free_en) begin
            full_d[obank_q] = 1'b0;
        end

        if (wr_en) begin
            if (wcnt_q == '0) begin
                inv_d[wbank_q] = in_inv;
            end
            if (wcnt_q == WLAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (advance) begin
            valid_d = full_q[rbank_q];
            if (full_q[rbank_q]) begin
                for (int j = 0; j < int'(R); j++) begin
                    lane_d[j*DW +: DW] = mem_q[rbank_q][WW'(j * R) + WW'(rcnt_q)];
                end
                inv_out_d = inv_q[rbank_q];
                last_d    = (rcnt_q == RLAST);
                obank_d   = rbank_q;
                if (rcnt_q == RLAST) begin
                    rbank_d = ~rbank_q;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q   <= 1'b0;
            wcnt_q    <= '0;
            full_q    <= '0;
            inv_q     <= '0;
            rbank_q   <= 1'b0;
            rcnt_q    <= '0;
            lane_q    <= '0;
            valid_q   <= 1'b0;
            inv_out_q <= 1'b0;
            last_q    <= 1'b0;
            obank_q   <= 1'b0;
        end else begin
            wbank_q   <= wbank_d;
            wcnt_q    <= wcnt_d;
            full_q    <= full_d;
            inv_q     <= inv_d;
            rbank_q   <= rbank_d;
            rcnt_q    <= rcnt_d;
            lane_q    <= lane_d;
            valid_q   <= valid_d;
            inv_out_q <= inv_out_d;
            last_q    <= last_d;
            obank_q   <= obank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wbank_q][wcnt_q] <= wr_data;
        end
    end

endmodule
